cic3_decim_fifo: RTL and testbench

Output stage directly downstream of the CIC3 decimator in the sigma-delta receive chain. Samples the 25-bit CIC output once per decimation period, rescales it to a 16-bit signed word, and buffers it in a small FIFO. A read handshake drains the FIFO, typically from the register/SPI readout logic. Full, empty and sticky overflow status are provided.

---
 rtl/cic3_decim_fifo.sv | 134 +++++++++++++
 tb/tb_cic3_decim_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cic3_decim_fifo.sv
// CIC3 output stage: decimate, rescale to OUT_WIDTH, buffer in a FIFO. Optional macro CIC_ROUND_SAT_EN.
// Latency: smp cycle to fifo_count update is 3 edges; read data 1 cycle after rd_en. Full FIFO drops samples (sticky overflow).
module cic3_decim_fifo #(
    parameter int IN_WIDTH   = 25,
    parameter int OUT_WIDTH  = 16,
    parameter int DECIMATION = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [IN_WIDTH-1:0]           cic_in,
    input  logic                          rd_en,
    input  logic                          clear_overflow,
    output logic [OUT_WIDTH-1:0]          rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          empty,
    output logic                          full,
    output logic                          overflow
);
    localparam int SH = IN_WIDTH - OUT_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(DECIMATION);

    logic [DW-1:0]                dcnt_q, dcnt_d;
    logic                         smp;
    logic signed [IN_WIDTH-1:0]   cap_q, cap_d;
    logic                         v1_q, v1_d, v2_q, v2_d;
    logic [OUT_WIDTH-1:0]         scl_q, scl_d;
    logic [AW-1:0]                wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic                         empty_q, empty_d, full_q, full_d;
    logic                         ovf_q, ovf_d, rdv_q, rdv_d;
    logic [OUT_WIDTH-1:0]         rdd_q, rdd_d;
    logic [OUT_WIDTH-1:0]         mem_q [FIFO_DEPTH];
    logic                         rd_fire, wr_fire, drop;

`ifdef CIC_ROUND_SAT_EN
    localparam logic signed [IN_WIDTH:0] RND     = (IN_WIDTH+1)'(1) << (SH-1);
    localparam logic signed [IN_WIDTH:0] SAT_MAX = (IN_WIDTH+1)'((1 << (OUT_WIDTH-1)) - 1);
    localparam logic signed [IN_WIDTH:0] SAT_MIN = ~SAT_MAX;
    logic signed [IN_WIDTH:0] rnd_sum, rnd_shr;

    // One guard bit keeps the rounding add from wrapping near full scale.
    always_comb begin
        rnd_sum = {cap_q[IN_WIDTH-1], cap_q} + RND;
        rnd_shr = rnd_sum >>> SH;
        if (rnd_shr > SAT_MAX)
            scl_d = SAT_MAX[OUT_WIDTH-1:0];
        else if (rnd_shr < SAT_MIN)
            scl_d = SAT_MIN[OUT_WIDTH-1:0];
        else
            scl_d = rnd_shr[OUT_WIDTH-1:0];
    end
`else
    logic unused_lsbs;
    assign unused_lsbs = ^cap_q[SH-1:0];

    // Dropping the low SH bits is exactly an arithmetic shift; the result always fits.
    always_comb begin
        scl_d = cap_q[IN_WIDTH-1:SH];
    end
`endif

    always_comb begin
        smp     = (dcnt_q == DW'(DECIMATION-1));
        dcnt_d  = smp ? '0 : dcnt_q + DW'(1);
        cap_d   = smp ? cic_in : cap_q;
        v1_d    = smp;
        v2_d    = v1_q;
        rd_fire = rd_en && !empty_q;
        // A read on a full FIFO frees the slot the write lands in.
        wr_fire = v2_q && (!full_q || rd_fire);
        drop    = v2_q && full_q && !rd_fire;
        wptr_d  = wr_fire ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = rd_fire ? rptr_q + AW'(1) : rptr_q;
        cnt_d   = cnt_q + CW'(wr_fire) - CW'(rd_fire);
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == CW'(FIFO_DEPTH));
        rdv_d   = rd_fire;
        rdd_d   = rd_fire ? mem_q[rptr_q] : rdd_q;
        if (drop)
            ovf_d = 1'b1;
        else if (clear_overflow)
            ovf_d = 1'b0;
        else
            ovf_d = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt_q  <= '0;
            cap_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            scl_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            rdv_q   <= 1'b0;
            rdd_q   <= '0;
        end else begin
            dcnt_q  <= dcnt_d;
            cap_q   <= cap_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            scl_q   <= scl_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            rdv_q   <= rdv_d;
            rdd_q   <= rdd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_fire)
            mem_q[wptr_q] <= scl_q;
    end

    assign rd_data    = rdd_q;
    assign rd_valid   = rdv_q;
    assign fifo_count = cnt_q;
    assign empty      = empty_q;
    assign full       = full_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_cic3_decim_fifo.sv
// Bench for cic3_decim_fifo: timing-level reference model plus directed literal checks.
module tb_cic3_decim_fifo;
    localparam int IW = 25, OW = 16, DEC = 64, DEPTH = 16, SH = IW - OW;

    logic          clk = 1'b0, reset = 1'b1, rd_en = 1'b0, clear_overflow = 1'b0;
    logic [IW-1:0] cic_in = '0;
    logic [OW-1:0] rd_data;
    logic          rd_valid, empty, full, overflow;
    logic [$clog2(DEPTH):0] fifo_count;

    cic3_decim_fifo #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DECIMATION(DEC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .cic_in(cic_in), .rd_en(rd_en),
        .clear_overflow(clear_overflow), .rd_data(rd_data), .rd_valid(rd_valid),
        .fifo_count(fifo_count), .empty(empty), .full(full), .overflow(overflow));

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Reference model: sample value as defined by the scaling rule.
    function automatic logic [15:0] scale(input logic [IW-1:0] x);
        longint v;
        v = longint'($signed(x));
`ifdef CIC_ROUND_SAT_EN
        v = (v + (longint'(1) << (SH-1))) >>> SH;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
`else
        v = v >>> SH;
`endif
        return v[15:0];
    endfunction

    // Model state: edges since reset release, FIFO contents, samples waiting to be written.
    int          mt = 0, mwr_ev = 0;
    logic [15:0] mq[$];
    int          pdue[$];
    logic [15:0] pval[$];
    bit          movf = 0, mrdv = 0;
    logic [15:0] mrdd = '0;

    always @(posedge clk) begin : model
        bit rd, due, dropped;
        if (reset) begin
            mt = 0; mq.delete(); pdue.delete(); pval.delete();
            movf = 0; mrdv = 0; mrdd = '0;
        end else begin
            rd  = rd_en && (mq.size() > 0);
            due = (pdue.size() > 0) && (pdue[0] == mt);
            dropped = 0;
            if (rd) begin mrdd = mq.pop_front(); mrdv = 1; end
            else mrdv = 0;
            if (due) begin
                void'(pdue.pop_front());
                mwr_ev++;
                if (mq.size() < DEPTH) mq.push_back(pval.pop_front());
                else begin void'(pval.pop_front()); dropped = 1; end
            end
            if (dropped) movf = 1;
            else if (clear_overflow) movf = 0;
            if ((mt % DEC) == DEC - 1) begin
                pdue.push_back(mt + 2);
                pval.push_back(scale(cic_in));
            end
            mt++;
        end
    end

    always @(negedge clk) begin : compare
        chk("count",    32'(fifo_count), 32'(mq.size()));
        chk("empty",    32'(empty),      32'(mq.size() == 0));
        chk("full",     32'(full),       32'(mq.size() == DEPTH));
        chk("overflow", 32'(overflow),   32'(movf));
        chk("rd_valid", 32'(rd_valid),   32'(mrdv));
        chk("rd_data",  32'(rd_data),    32'(mrdd));
    end

    task automatic wait_write();
        int start = mwr_ev;
        int n = 0;
        while (mwr_ev == start && n < 300) begin @(negedge clk); n++; end
        if (mwr_ev == start) timeout("wait_write");
    endtask

    task automatic drain(output logic [15:0] last);
        int n = 0;
        last = '0;
        while (mq.size() > 0 && n < 100) begin
            rd_en = 1'b1;
            @(negedge clk);
            n++;
            if (rd_valid) last = rd_data;
        end
        rd_en = 1'b0;
        if (mq.size() > 0) timeout("drain");
    endtask

    task automatic sync();
        logic [15:0] d;
        wait_write();
        drain(d);
    endtask

    task automatic sample_and_read(input logic [IW-1:0] val, input logic [15:0] exp, input string name);
        logic [15:0] last;
        cic_in = val;
        wait_write();
        wait_write();
        drain(last);
        chk(name, 32'(last), 32'(exp));
    endtask

    // From a reset release: count is 0 for 65 edges, 1 after the 66th, and the value reads back.
    task automatic first_sample(input logic [15:0] exp, input string name);
        repeat (65) @(negedge clk);
        chk({name, "_cnt0"}, 32'(fifo_count), 32'd0);
        @(negedge clk);
        chk({name, "_cnt1"}, 32'(fifo_count), 32'd1);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk({name, "_vld"},  32'(rd_valid), 32'd1);
        chk({name, "_data"}, 32'(rd_data),  32'(exp));
        @(negedge clk);
        chk({name, "_pulse"}, 32'(rd_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] last;
        int n;
        // Reset and first sample
        cic_in = 25'd512;
        repeat (10) @(negedge clk);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_data",  32'(rd_data), 32'd0);
        reset = 1'b0;
        first_sample(16'h0001, "first");

        // Rounding and saturation
`ifdef CIC_ROUND_SAT_EN
        sample_and_read(25'd256, 16'h0001, "round_256");
`else
        sample_and_read(25'd256, 16'h0000, "round_256");
`endif
        sample_and_read(-25'sd257,              16'hFFFF, "round_m257");
        sample_and_read(25'h0FFFFFF,            16'h7FFF, "sat_pos");
        sample_and_read(25'h1000000,            16'h8000, "sat_neg");

        // Overflow with no reads for 17 periods
        sync();
        for (int k = 1; k <= 17; k++) begin
            cic_in = IW'(k * 512);
            wait_write();
            if (k == 16) begin
                chk("ovf_full16", 32'(full), 32'd1);
                chk("ovf_flag16", 32'(overflow), 32'd0);
            end
        end
        chk("ovf_set",   32'(overflow),   32'd1);
        chk("ovf_count", 32'(fifo_count), 32'd16);
        for (int k = 1; k <= 16; k++) begin
            rd_en = 1'b1;
            @(negedge clk);
            chk("ovf_order", 32'(rd_data), 32'(k));
        end
        rd_en = 1'b0;
        @(negedge clk);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        chk("ovf_clear", 32'(overflow), 32'd0);

        // Simultaneous write and read at full
        sync();
        for (int k = 1; k <= 16; k++) begin
            cic_in = IW'((100 + k) * 512);
            wait_write();
        end
        cic_in = IW'(117 * 512);
        n = 0;
        while (!(pdue.size() > 0 && pdue[0] == mt) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) timeout("wr_cycle");
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("sim_count", 32'(fifo_count), 32'd16);
        chk("sim_ovf",   32'(overflow),   32'd0);
        chk("sim_first", 32'(rd_data),    32'd101);
        drain(last);
        chk("sim_last",  32'(last),       32'd117);

        // Reset mid-operation with 5 entries and a sample in flight
        sync();
        for (int k = 1; k <= 5; k++) begin
            cic_in = IW'((200 + k) * 512);
            wait_write();
        end
        cic_in = IW'(206 * 512);
        n = 0;
        while (pdue.size() == 0 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) timeout("smp_wait");
        chk("mid_held", 32'(fifo_count), 32'd5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cic_in = IW'(300 * 512);
        chk("mid_count", 32'(fifo_count), 32'd0);
        chk("mid_empty", 32'(empty),      32'd1);
        chk("mid_rdv",   32'(rd_valid),   32'd0);
        first_sample(16'd300, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
